// File: rtl/requant_pkg.sv
// Shared sizes, int8 limits and FSM encoding for the requantizing serializer.
// Imported by the top and the per-lane arithmetic pipeline.
package requant_pkg;
  localparam int LANES    = 4;
  localparam int ACC_W    = 24;
  localparam int MULT_W   = 16;
  localparam int SHIFT_W  = 5;
  localparam int PROD_W   = ACC_W + MULT_W + 1;
  localparam int INT8_MAX = 127;
  localparam int INT8_MIN = -128;

  typedef enum logic {
    IDLE   = 1'b0,
    SERIAL = 1'b1
  } state_t;
endpackage

// File: rtl/requant_lane.sv
// Two-stage requant pipeline: signed multiply, then round-half-up shift, ReLU, int8 saturate.
// Config and sideband travel with each operand, so in-flight lanes ignore later config changes.
module requant_lane #(
  parameter int ACC_W   = 24,
  parameter int MULT_W  = 16,
  parameter int SHIFT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  input  logic               in_last,
  input  logic [ACC_W-1:0]   in_acc,
  input  logic [MULT_W-1:0]  mult,
  input  logic [SHIFT_W-1:0] shift,
  input  logic               relu,
  output logic               out_valid,
  output logic [ACC_W-1:0]   out_data,
  output logic               out_last
);
  import requant_pkg::*;

  localparam int PW = ACC_W + MULT_W + 1;
  localparam logic signed [PW-1:0] SAT_MAX = PW'(INT8_MAX);
  localparam logic signed [PW-1:0] SAT_MIN = PW'(INT8_MIN);

  logic                   s1_valid, s1_last, s1_relu;
  logic signed [PW-1:0]   s1_prod;
  logic [SHIFT_W-1:0]     s1_shift;
  logic signed [PW-1:0]   prod_c, rnd, r;
  logic signed [7:0]      sat8;

  // Multiplier is unsigned, so a zero MSB makes it a non-negative signed operand.
  assign prod_c = PW'($signed(in_acc)) * PW'($signed({1'b0, mult}));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_relu  <= 1'b0;
      s1_prod  <= '0;
      s1_shift <= '0;
    end else begin
      s1_valid <= in_valid && !clear;
      s1_last  <= in_last && !clear;
      if (in_valid) begin
        s1_prod  <= prod_c;
        s1_shift <= shift;
        s1_relu  <= relu;
      end
    end
  end

  always_comb begin
    rnd = '0;
    if (s1_shift != '0) rnd = PW'(1) << (s1_shift - SHIFT_W'(1));
    r = (s1_prod + rnd) >>> s1_shift;
    if (s1_relu && r < 0) r = '0;
    if (r > SAT_MAX)      sat8 = 8'sd127;
    else if (r < SAT_MIN) sat8 = -8'sd128;
    else                  sat8 = r[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= s1_valid && !clear;
      out_last  <= s1_last && s1_valid && !clear;
      if (s1_valid) out_data <= {{(ACC_W-8){sat8[7]}}, sat8};
    end
  end
endmodule

// File: rtl/requant_serializer.sv
// Latches a group of accumulators with its scale config and issues one lane per cycle into the lane pipeline.
// Bytes appear two edges after issue; output is never stalled, acc_ready depends on state only.
module requant_serializer #(
  parameter int LANES   = 4,
  parameter int ACC_W   = 24,
  parameter int MULT_W  = 16,
  parameter int SHIFT_W = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   acc_valid,
  output logic                   acc_ready,
  input  logic [LANES*ACC_W-1:0] acc_data,
  input  logic [MULT_W-1:0]      scale_mult,
  input  logic [SHIFT_W-1:0]     scale_shift,
  input  logic                   relu_en,
  output logic                   out_valid,
  output logic [ACC_W-1:0]       out_data,
  output logic                   out_last
);
  import requant_pkg::*;

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  state_t                 state, state_nxt;
  logic [LANE_W-1:0]      lane, lane_nxt;
  logic [LANES*ACC_W-1:0] acc_buf;
  logic [MULT_W-1:0]      mult_buf;
  logic [SHIFT_W-1:0]     shift_buf;
  logic                   relu_buf;
  logic                   last_lane, accept, issue;

  assign last_lane = (lane == LANE_W'(LANES - 1));
  assign acc_ready = (state == IDLE) || (state == SERIAL && last_lane);
  assign accept    = acc_valid && acc_ready && !clear;
  assign issue     = (state == SERIAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lane  <= '0;
    end else begin
      state <= state_nxt;
      lane  <= lane_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    lane_nxt  = lane;
    if (clear) begin
      state_nxt = IDLE;
      lane_nxt  = '0;
    end else if (accept) begin
      state_nxt = SERIAL;
      lane_nxt  = '0;
    end else if (state == SERIAL) begin
      if (last_lane) begin
        state_nxt = IDLE;
        lane_nxt  = '0;
      end else begin
        lane_nxt = lane + LANE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_buf   <= '0;
      mult_buf  <= '0;
      shift_buf <= '0;
      relu_buf  <= 1'b0;
    end else if (accept) begin
      acc_buf   <= acc_data;
      mult_buf  <= scale_mult;
      shift_buf <= scale_shift;
      relu_buf  <= relu_en;
    end
  end

  requant_lane #(
    .ACC_W  (ACC_W),
    .MULT_W (MULT_W),
    .SHIFT_W(SHIFT_W)
  ) u_lane (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_valid (issue),
    .in_last  (issue && last_lane),
    .in_acc   (acc_buf[lane*ACC_W +: ACC_W]),
    .mult     (mult_buf),
    .shift    (shift_buf),
    .relu     (relu_buf),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last)
  );
endmodule

// File: tb/tb_requant_serializer.sv
// Directed bench for requant_serializer: a scoreboard queue holds expected bytes, last flags and arrival cycles.
// A negedge monitor pops one entry per out_valid byte; any byte with an empty queue is flagged.
module tb_requant_serializer;
  logic          clk, rst_n, clear, acc_valid, acc_ready, relu_en;
  logic [95:0]   acc_data;
  logic [15:0]   scale_mult;
  logic [4:0]    scale_shift;
  logic          out_valid, out_last;
  logic [23:0]   out_data;

  typedef struct {
    logic [23:0] d;
    logic        l;
    int          c;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;
  int   acc_edge;
  int   acc_log[$];

  requant_serializer dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data),
    .scale_mult(scale_mult), .scale_shift(scale_shift), .relu_en(relu_en),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic int model(int acc, int mult, int sh, bit relu);
    longint p, r;
    p = longint'(acc) * longint'(mult);
    if (sh == 0) r = p;
    else r = (p + (longint'(1) << (sh - 1))) >>> sh;
    if (relu && r < 0) r = 0;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return int'(r);
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_byte", {8'h0, out_data}, 32'hDEAD);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_data", {8'h0, out_data}, {8'h0, e.d});
        check("out_last", {31'h0, out_last}, {31'h0, e.l});
        check("out_cycle", cyc, e.c);
      end
    end
  end

  // Drives one group and pushes the first n_exp expected lanes once it is accepted.
  // acc_valid is left high so callers can chain groups back to back.
  task automatic send_group(input int a[4], input int mult, input int sh, input bit relu,
                            input int e[4], input int n_exp);
    int w;
    bit ok;
    for (int k = 0; k < 4; k++) acc_data[k*24 +: 24] = a[k][23:0];
    scale_mult  = mult[15:0];
    scale_shift = sh[4:0];
    relu_en     = relu;
    acc_valid   = 1'b1;
    w = 0;
    while (!acc_ready && w < 20) begin
      @(posedge clk);
      #1;
      w++;
    end
    ok = acc_ready;
    check("accept_timeout", {31'h0, ok}, 32'h1);
    @(posedge clk);
    #1;
    acc_edge = cyc;
    acc_log.push_back(cyc);
    for (int k = 0; k < n_exp; k++) begin
      exp_t x;
      x.d = e[k][23:0];
      x.l = (k == 3);
      x.c = acc_edge + 2 + k;
      sb.push_back(x);
    end
  endtask

  task automatic send_m(input int a[4], input int mult, input int sh, input bit relu);
    int e[4];
    for (int k = 0; k < 4; k++) e[k] = model(a[k], mult, sh, relu);
    send_group(a, mult, sh, relu, e, 4);
  endtask

  task automatic drain();
    repeat (8) @(posedge clk);
    #1;
    check("drained", sb.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; acc_valid = 1'b0; acc_data = '0;
    scale_mult = '0; scale_shift = '0; relu_en = 1'b0;
    #1;
    check("rst_out_valid", {31'h0, out_valid}, 0);
    check("rst_out_data",  {8'h0, out_data}, 0);
    check("rst_out_last",  {31'h0, out_last}, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_acc_ready", {31'h0, acc_ready}, 1);
    check("idle_out_valid", {31'h0, out_valid}, 0);
    check("idle_out_data",  {8'h0, out_data}, 0);

    // Rounding: 125, 126, -125, -125 as constants
    send_group('{1000, 1004, -1004, -1000}, 1, 3, 1'b0,
               '{32'h7D, 32'h7E, 32'hFFFFFF83, 32'hFFFFFF83}, 4);
    acc_valid = 1'b0;
    check("serial_acc_ready", {31'h0, acc_ready}, 0);
    drain();

    send_group('{100000, -100000, -5, 7}, 1, 0, 1'b0, '{127, -128, -5, 7}, 4);
    acc_valid = 1'b0;
    drain();
    send_group('{100000, -100000, -5, 7}, 1, 0, 1'b1, '{127, 0, 0, 7}, 4);
    acc_valid = 1'b0;
    drain();

    // Scaling with a config change while the group is still in flight
    send_group('{300, 300, -300, 41}, 3, 2, 1'b0, '{127, 127, -128, 31}, 4);
    acc_valid = 1'b0;
    scale_mult = 16'd7; scale_shift = 5'd0; relu_en = 1'b1;
    drain();

    // Back-to-back with acc_valid held high
    acc_log.delete();
    send_m('{5000, -5000, 123, -77}, 200, 10, 1'b0);
    send_m('{-8388608, 8388607, 0, 1}, 65535, 31, 1'b0);
    send_m('{640, -641, 63, -65}, 1, 7, 1'b1);
    acc_valid = 1'b0;
    check("b2b_gap1", acc_log[1] - acc_log[0], 4);
    check("b2b_gap2", acc_log[2] - acc_log[1], 4);
    drain();

    // Clear after lane 1 has left stage 1: only lanes 0 and 1 reach the output
    send_group('{10, 20, 30, 40}, 1, 0, 1'b0, '{10, 20, 30, 40}, 2);
    acc_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    check("clear_out_valid", {31'h0, out_valid}, 0);
    check("clear_acc_ready", {31'h0, acc_ready}, 1);
    drain();

    // Clear coincident with a valid group accepts nothing
    for (int k = 0; k < 4; k++) acc_data[k*24 +: 24] = 24'd50;
    acc_valid = 1'b1; clear = 1'b1;
    @(posedge clk);
    #1 acc_valid = 1'b0; clear = 1'b0;
    check("clear_acc_no_accept", {31'h0, acc_ready}, 1);
    drain();

    // Async reset mid-group: only lane 0 is observed before reset
    send_group('{-90, 91, -92, 93}, 1, 0, 1'b0, '{-90, 91, -92, 93}, 1);
    acc_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_out_valid", {31'h0, out_valid}, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'h0, out_valid}, 0);
    check("midrst_out_data",  {8'h0, out_data}, 0);
    check("midrst_out_last",  {31'h0, out_last}, 0);
    check("midrst_acc_ready", {31'h0, acc_ready}, 1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/requant_serializer.md
# requant_serializer

Requantizes a group of four 24-bit signed PE accumulator results to int8 and streams them one per cycle into the byte packer that builds 32-bit output words. It sits between the 4-PE accumulator array and the packer. It accepts a whole group with a valid/ready handshake. Each lane goes through a 2-stage multiply / round-shift / ReLU / saturate pipeline. Output is a gap-free 4-cycle byte stream with no backpressure, because the packer has none.

## Interface
Parameters:
- LANES, 4: accumulators per group (PE count).
- ACC_W, 24: accumulator width, signed.
- MULT_W, 16: scale multiplier width, unsigned.
- SHIFT_W, 5: right-shift amount width.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush of buffer and pipeline.
- acc_valid  in  1  group on acc_data is valid.
- acc_ready  out  1  block can accept a group this cycle.
- acc_data  in  LANES*ACC_W  lane i at [i*ACC_W +: ACC_W], signed.
- scale_mult  in  MULT_W  unsigned multiplier, sampled with the group.
- scale_shift  in  SHIFT_W  arithmetic right shift, sampled with the group.
- relu_en  in  1  clamp negatives to 0, sampled with the group.
- out_valid  out  1  out_data holds a byte; feeds packer in_valid.
- out_data  out  ACC_W  int8 result sign-extended to ACC_W; feeds packer in_data.
- out_last  out  1  high with lane LANES-1 of a group.

## Operation
- FSM states:
  - IDLE: acc_ready=1.
  - SERIAL: issues lanes in order, lane counter 0..LANES-1.
- Handshake: a group is accepted on an edge where acc_valid && acc_ready.
  - On accept, acc_data, scale_mult, scale_shift and relu_en are latched into the group buffer.
  - The FSM then goes to SERIAL with lane=0.
- acc_ready = (state==IDLE) || (state==SERIAL && lane==LANES-1). This allows back-to-back groups.
- In SERIAL, one lane enters the pipeline per cycle. After lane LANES-1:
  - go to IDLE if no accept on that edge;
  - otherwise reload the buffer and restart at lane 0.
- Stage 1: prod = signed(acc) * signed({1'b0, scale_mult}), 41-bit, registered.
- Stage 2:
  - If shift==0, r = prod. Otherwise r = (prod + (1 << (shift-1))) >>> shift, which is round-half-up toward +inf.
  - If relu_en and r<0, r=0.
  - Saturate to [-128, 127].
  - Register the result as a sign-extended value in out_data.
- out_last travels with lane LANES-1 through both stages.
- clear:
  - Returns to IDLE, drops the buffer, and zeroes the stage 1 valid, out_valid and out_last at the next edge.
  - Has priority over an accept on the same edge; that group is lost.
- Reset mid-group: all state returns to reset values immediately; no partial output completes.

## Timing
- Reset values:
  - state=IDLE, so acc_ready=1.
  - out_valid=0, out_data=0, out_last=0.
  - lane=0; stage 1 valid=0.
- Latency: for a group accepted at edge E0, lane k is on the outputs after edge E(2+k). out_valid is high for the 4 cycles following E2..E5, and out_last is high in the cycle after E5.
- Throughput: 1 byte/cycle. With acc_valid held high, groups are accepted every 4 edges and out_valid stays high continuously.
- out_valid never depends combinationally on inputs. acc_ready depends on state only, not on acc_valid.
- Config changes between groups take effect only for groups accepted after the change.

## Structure
- Package requant_pkg holds:
  - LANES, ACC_W, MULT_W, SHIFT_W, PROD_W (=ACC_W+MULT_W+1);
  - INT8_MAX=127 and INT8_MIN=-128;
  - the FSM state enum {IDLE, SERIAL}.
- Sub-module requant_lane holds the 2-stage arithmetic pipeline (multiply, round-shift, ReLU, saturate, valid/last sideband). The top holds the FSM, group buffer and lane mux.

## Test plan
- Reset then idle: after rst_n release, acc_ready=1, out_valid=0, out_data=0.
- Group {1000, 1004, -1004, -1000}, mult=1, shift=3, relu=0, accepted at E0:
  - outputs after E2..E5 are 125, 126, -125, -125, i.e. 24'h00007D, 24'h00007E, 24'hFFFF83, 24'hFFFF83;
  - out_last is high only on the 4th byte.
- Saturation and ReLU:
  - group {100000, -100000, -5, 7}, mult=1, shift=0, relu=0 -> 127, -128, -5, 7;
  - the same group with relu=1 -> 127, 0, 0, 7.
- Back-to-back: acc_valid held high for 3 groups.
  - acc_ready pulses at E0, E4, E8;
  - out_valid is high for 12 consecutive cycles;
  - 4 bytes are loaded into the packer per group.
- Scaling: acc=300, mult=3, shift=2 -> (900+2)>>>2 = 225 -> saturates to 127. A new config applied mid-group does not alter the in-flight group.
- Flush: assert clear after lane 1 leaves stage 1.
  - No further out_valid appears and acc_ready=1 next cycle.
  - A clear coincident with acc_valid accepts nothing.
  - Async rst_n low mid-group zeroes the outputs immediately.
